// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, FSM states and default sizes for the stack controller
package stack_pkg;

    localparam int W_DEF  = 8;
    localparam int AW_DEF = 4;

    // Same encoding as the stack-pointer control path, so op decode is identical everywhere
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_CLR  = 2'b01,
        OP_PUSH = 2'b10,
        OP_POP  = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - op request and pop result handshakes between control unit and stack_ctrl
// Signals: op_valid/op_ready/op/push_data (request), pop_data/pop_valid/pop_ready (result)
// master = control unit side, slave = stack_ctrl side
interface stack_ctrl_if #(
    parameter int W = 8
) ();
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op;
    logic [W-1:0] push_data;
    logic [W-1:0] pop_data;
    logic         pop_valid;
    logic         pop_ready;

    modport master (
        output op_valid, op, push_data, pop_ready,
        input  op_ready, pop_data, pop_valid
    );

    modport slave (
        input  op_valid, op, push_data, pop_ready,
        output op_ready, pop_data, pop_valid
    );
endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - DEPTH x W stack storage, one sync write port, one sync read port, no reset
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request, rd_data registered result
module stack_ram #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2**AW];

    // rd_data only moves on a read request, so it holds a popped word until the next read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - stack pointer, sticky flags and push/pop handshake in front of stack_ram
// Optional feature macro: STACK_PEEK_EN (adds tos/tos_valid top-of-stack outputs)
// Ports: clk, rst_n (async active-low); bus (stack_ctrl_if.slave: op request and pop result);
//        sp (next free slot), full, empty, err_ovf, err_unf; tos, tos_valid with STACK_PEEK_EN
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    stack_ctrl_if.slave  bus,
    output logic [AW:0]  sp,
    output logic         full,
    output logic         empty,
    output logic         err_ovf,
`ifdef STACK_PEEK_EN
    output logic         err_unf,
    output logic [W-1:0] tos,
    output logic         tos_valid
`else
    output logic         err_unf
`endif
);
    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW:0]   sp_q, sp_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;
    logic          accept, do_push, do_pop, pop_valid;
    op_e           op_in;
    logic          ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [W-1:0]  ram_rd_data;

    assign op_in         = op_e'(bus.op);
    assign full          = (sp_q == SP_FULL);
    assign empty         = (sp_q == '0);
    assign sp            = sp_q;
    assign err_ovf       = err_ovf_q;
    assign err_unf       = err_unf_q;
    assign pop_valid     = (state_q == RESP);
    assign bus.pop_valid = pop_valid;
    assign bus.op_ready  = (state_q == IDLE);
    // A push on full or pop on empty is still accepted; it only raises the sticky flag
    assign accept        = bus.op_valid && (state_q == IDLE);
    assign do_push       = accept && (op_in == OP_PUSH) && !full;
    assign do_pop        = accept && (op_in == OP_POP) && !empty;

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_in)
                        OP_CLR: begin
                            sp_d      = '0;
                            err_ovf_d = 1'b0;
                            err_unf_d = 1'b0;
                        end
                        OP_PUSH: begin
                            if (full) err_ovf_d = 1'b1;
                            else      sp_d      = sp_q + SP_ONE;
                        end
                        OP_POP: begin
                            if (empty) begin
                                err_unf_d = 1'b1;
                            end else begin
                                sp_d    = sp_q - SP_ONE;
                                state_d = RESP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RESP: begin
                if (bus.pop_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sp_q      <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

`ifdef STACK_PEEK_EN
    logic [W-1:0] tos_q, tos_d;
    logic [W-1:0] pop_data_q, pop_data_d;
    logic         tos_ram_q, tos_ram_d;

    // The popped word is already the top-of-stack value, so the one read port is
    // spent fetching the word underneath it, which becomes the new top.
    assign ram_rd_en     = do_pop && (sp_q > SP_ONE);
    assign ram_rd_addr   = sp_q[AW-1:0] - AW'(2);
    assign tos           = tos_ram_q ? ram_rd_data : tos_q;
    assign tos_valid     = !empty;
    assign bus.pop_data  = pop_data_q;

    always_comb begin
        tos_d      = tos_q;
        tos_ram_d  = tos_ram_q;
        pop_data_d = pop_data_q;
        if (do_push) begin
            tos_d     = bus.push_data;
            tos_ram_d = 1'b0;
        end else if (do_pop) begin
            pop_data_d = tos;
            tos_ram_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos_q      <= '0;
            tos_ram_q  <= 1'b0;
            pop_data_q <= '0;
        end else begin
            tos_q      <= tos_d;
            tos_ram_q  <= tos_ram_d;
            pop_data_q <= pop_data_d;
        end
    end
`else
    assign ram_rd_en    = do_pop;
    assign ram_rd_addr  = sp_q[AW-1:0] - AW'(1);
    // RAM read register has no reset; pop_data reads 0 whenever no result is held
    assign bus.pop_data = pop_valid ? ram_rd_data : '0;
`endif

    stack_ram #(
        .W  (W),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (sp_q[AW-1:0]),
        .wr_data (bus.push_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );
endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl against a queue-based stack model
module tb_stack_ctrl;
    import stack_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] sp;
    logic       full, empty, err_ovf, err_unf;
`ifdef STACK_PEEK_EN
    logic [7:0] tos;
    logic       tos_valid;
`endif

    stack_ctrl_if #(.W(8)) bus ();

    stack_ctrl #(.W(8), .AW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sp        (sp),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
`ifdef STACK_PEEK_EN
        .err_unf   (err_unf),
        .tos       (tos),
        .tos_valid (tos_valid)
`else
        .err_unf   (err_unf)
`endif
    );

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] model[$];
    logic [7:0] exp_q[$];
    logic       m_ovf, m_unf;
    logic       rand_rdy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance
    task automatic do_op(input logic [1:0] o, input logic [7:0] d);
        int   n;
        logic exp_pv;
        n = 0;
        bus.op_valid  = 1'b1;
        bus.op        = o;
        bus.push_data = d;
        if (rand_rdy) bus.pop_ready = 1'($urandom_range(0, 1));
        while (!bus.op_ready && n < 50) begin
            @(negedge clk);
            n++;
            if (rand_rdy) bus.pop_ready = 1'($urandom_range(0, 1));
        end
        if (!bus.op_ready) begin
            chk("op_accept_timeout", 32'(bus.op_ready), 1);
            bus.op_valid = 1'b0;
            return;
        end
        exp_pv = 1'b0;
        case (op_e'(o))
            OP_CLR: begin
                model.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            OP_PUSH: begin
                if (model.size() < 16) model.push_back(d);
                else m_ovf = 1'b1;
            end
            OP_POP: begin
                if (model.size() > 0) begin
                    exp_q.push_back(model.pop_back());
                    exp_pv = 1'b1;
                end else begin
                    m_unf = 1'b1;
                end
            end
            default: ;
        endcase
        @(negedge clk);
        bus.op_valid = 1'b0;
        chk("sp", 32'(sp), 32'(model.size()));
        chk("full", 32'(full), 32'(model.size() == 16));
        chk("empty", 32'(empty), 32'(model.size() == 0));
        chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("err_unf", 32'(err_unf), 32'(m_unf));
        chk("pop_valid_after_op", 32'(bus.pop_valid), 32'(exp_pv));
        chk("op_ready_after_op", 32'(bus.op_ready), 32'(!exp_pv));
`ifdef STACK_PEEK_EN
        chk("tos_valid", 32'(tos_valid), 32'(model.size() > 0));
        if (model.size() > 0) chk("tos", 32'(tos), 32'(model[$]));
`endif
    endtask

    // Monitor: compare pop_data on each pop handshake and check it holds under backpressure
    initial begin
        logic       pend;
        logic [7:0] pd;
        logic [7:0] e;
        pend = 1'b0;
        pd   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (bus.pop_valid && pend) chk("pop_hold", 32'(bus.pop_data), 32'(pd));
                if (bus.pop_valid && bus.pop_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_unexpected", 32'(bus.pop_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pop_data", 32'(bus.pop_data), 32'(e));
                    end
                end
                pend = bus.pop_valid && !bus.pop_ready;
                pd   = bus.pop_data;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.push_data = '0;
        bus.pop_ready = 1'b1;
        rand_rdy      = 1'b0;
        m_ovf         = 1'b0;
        m_unf         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sp", 32'(sp), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 0);
        chk("rst_pop_data", 32'(bus.pop_data), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back pushes then pops
        do_op(2'b10, 8'h11);
        do_op(2'b10, 8'h22);
        do_op(2'b10, 8'h33);
        repeat (3) do_op(2'b11, 8'h00);
        @(negedge clk);

        // Fill, overflow, then pop returns the last good word
        for (int i = 0; i < 16; i++) do_op(2'b10, 8'(i));
        do_op(2'b10, 8'hAA);
        do_op(2'b11, 8'h00);
        @(negedge clk);
        do_op(2'b01, 8'h00);

        // Underflow then clear
        do_op(2'b11, 8'h00);
        @(negedge clk);
        chk("unf_no_pop_valid", 32'(bus.pop_valid), 0);
        chk("unf_op_ready", 32'(bus.op_ready), 1);
        do_op(2'b00, 8'h00);
        do_op(2'b01, 8'h00);

        // Backpressure on the pop result
        do_op(2'b10, 8'h5A);
        bus.pop_ready = 1'b0;
        do_op(2'b11, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("bp_pop_valid", 32'(bus.pop_valid), 1);
            chk("bp_pop_data", 32'(bus.pop_data), 32'h5A);
            chk("bp_op_ready", 32'(bus.op_ready), 0);
            @(negedge clk);
        end
        bus.pop_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_pop_valid", 32'(bus.pop_valid), 0);
        chk("bp_release_op_ready", 32'(bus.op_ready), 1);

        // Reset while a pop result is held
        do_op(2'b10, 8'h77);
        do_op(2'b10, 8'h78);
        bus.pop_ready = 1'b0;
        do_op(2'b11, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pop_valid", 32'(bus.pop_valid), 0);
        chk("midrst_sp", 32'(sp), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_err_ovf", 32'(err_ovf), 0);
        chk("midrst_err_unf", 32'(err_unf), 0);
        model.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        bus.pop_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized ops with random consumer backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 42)      do_op(2'b10, 8'($urandom));
            else if (r < 84) do_op(2'b11, 8'h00);
            else if (r < 88) do_op(2'b01, 8'h00);
            else             do_op(2'b00, 8'($urandom));
        end
        rand_rdy = 1'b0;
        bus.pop_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("drain_scoreboard", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Push/pop front end that owns the stack pointer and the stack storage behind it.
- Accepts stack operations from the control unit over a valid/ready handshake, then steps the pointer and the internal stack RAM.
- The op encoding is the team's stack-pointer control encoding: 00 hold, 01 clear, 10 increment/push, 11 decrement/pop.
- Reports full/empty state and sticky overflow/underflow flags to the processor status logic.

Parameters:
W, 8, data word width
AW, 4, address width; DEPTH = 2**AW entries

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  operation request valid
op_ready  out  1  block can accept an operation this cycle
op  in  2  00 nop, 01 clear, 10 push, 11 pop
push_data  in  W  data for push, sampled on accept
pop_data  out  W  popped word, valid while pop_valid=1
pop_valid  out  1  pop result available
pop_ready  in  1  consumer takes pop_data
sp  out  AW+1  stack pointer, next free slot, range 0..DEPTH
full  out  1  sp==DEPTH
empty  out  1  sp==0
err_ovf  out  1  sticky: push attempted while full
err_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async on rst_n low, held until release):
  - sp=0, state=IDLE, pop_valid=0, pop_data=0, err_ovf=0, err_unf=0.
  - RAM contents are undefined, not cleared.
- Accept: an op is accepted on a rising edge with op_valid&&op_ready. op_ready=1 only in IDLE.
- States:
  - IDLE: accepts ops.
  - RESP: holds pop result. Entered only from an accepted pop with sp>0. Returns to IDLE on the edge where pop_valid&&pop_ready.
- nop (00): accepted, no effect.
- clear (01):
  - sp<=0, err_ovf<=0, err_unf<=0, next cycle.
  - RAM untouched; stays in IDLE.
- push (10):
  - If sp<DEPTH: mem[sp]<=push_data and sp<=sp+1, same edge; new sp visible next cycle.
  - If full: no write, sp unchanged, err_ovf<=1.
  - Stays in IDLE; back-to-back pushes run at 1 per cycle.
- pop (11):
  - If sp>0: RAM read address sp-1 is presented on the accept cycle T; sp<=sp-1.
  - Read data is registered into pop_data; pop_valid=1 from cycle T+1; state RESP.
  - pop_data and pop_valid are held stable until pop_ready; pop_valid drops the cycle after the handshake.
  - If empty: sp unchanged, err_unf<=1, no pop_valid, stays in IDLE.
- Pop throughput is 1 per 2 cycles when pop_ready is tied high.
- Arithmetic: sp is AW+1 bits and never wraps. full and empty are combinational from sp.
- Unknown/X op is never issued by the control unit; the verification engineer asserts this.
- Reset mid-pop (in RESP): pop_valid drops immediately (async); the pending word is lost.
- Error flags stay set until clear or reset. A push or pop rejected for full/empty is still considered accepted (op_ready was 1).

Optional Feature:
STACK_PEEK_EN
- Defined:
  - Adds output tos [W-1:0] and tos_valid; tos_valid = !empty.
  - tos is a registered copy of mem[sp-1], updated on the edge after any push, pop or clear.
  - On push, tos = the pushed word. On clear, tos_valid=0.
  - A shadow register holds the value; no second RAM read port.
- Undefined: tos and tos_valid ports are absent; no shadow register.

Decomposition:
- Shared package stack_pkg:
  - op codes OP_NOP=2'b00, OP_CLR=2'b01, OP_PUSH=2'b10, OP_POP=2'b11.
  - FSM state encoding IDLE/RESP.
  - Default W/AW.
- Op codes are the same values the stack-pointer control path already uses, so decode stays consistent across the processor.
- One sub-module, stack_ram:
  - DEPTH x W, one synchronous write port, one synchronous read port, registered read data, no reset.
  - stack_ctrl holds the FSM, sp, flags and handshake only.

Test Plan:
- Reset then idle: rst_n low mid-run -> sp=0, empty=1, full=0, pop_valid=0, err flags 0 immediately.
- Push 0x11,0x22,0x33 back-to-back, then 3 pops with pop_ready=1:
  - sp 0->1->2->3; pop_data 0x33, 0x22, 0x11, each with pop_valid one cycle after accept.
  - sp returns to 0, empty=1.
- Fill to DEPTH=16 with 0x00..0x0F:
  - full=1, sp=16.
  - 17th push 0xAA -> err_ovf=1, sp=16.
  - Following pop returns 0x0F, not 0xAA.
- Pop on empty -> err_unf=1, pop_valid never asserts, op_ready stays 1. Then clear -> both flags 0, sp=0.
- Backpressure: push 0x5A, pop with pop_ready=0 for 5 cycles:
  - pop_valid=1 and pop_data=0x5A stable, op_ready=0 throughout.
  - pop_ready=1 -> handshake; op_ready=1 next cycle.
- STACK_PEEK_EN build:
  - push 0x10 -> tos=0x10; push 0x20 -> tos=0x20.
  - pop -> tos=0x10; clear -> tos_valid=0.
